// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: prescaled six-phase LED show sequencer with phase mask and single-step
// clk25 tile clock, rst_n async active-low reset
// speed_sel step period 2^(3+speed_sel) clocks, phase_en per-phase enable mask
// hold ignore ticks and advance on step rising edges only, step single-step request
// led registered pattern, phase current phase code (6/7 idle), frame_done one-cycle end-of-frame pulse
module led_pattern_scheduler #(
  parameter int PRESCALE_W = 19
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [3:0] speed_sel,
  input  logic [5:0] phase_en,
  input  logic       hold,
  input  logic       step,
  output logic [7:0] led,
  output logic [2:0] phase,
  output logic       frame_done
);
  logic [PRESCALE_W-1:0] cnt, mask;
  logic step_q, tick, adv, wrap, found_lo, found_hi;
  logic [4:0] k, k_nxt, len;
  logic [2:0] phase_nxt, lo, hi, lot;
  logic [7:0] led_nxt;
  assign mask = ~({PRESCALE_W{1'b1}} << (5'(speed_sel) + 5'd3));
  assign tick = &(cnt | ~mask);
  assign adv = hold ? step & ~step_q : tick;
  assign len = phase == 3'd0 || phase == 3'd1 ? 5'd8 : phase == 3'd3 ? 5'd20 : phase == 3'd5 ? 5'd10 : 5'd16;
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      step_q <= 1'b0;
      phase <= 3'd7;
      k <= 5'd0;
      led <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      step_q <= step;
      phase <= phase_nxt;
      k <= k_nxt;
      led <= led_nxt;
      frame_done <= wrap & ~frame_done;
    end
  // descending scan leaves the lowest enabled code (lo) and the lowest enabled code above phase (hi)
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    lo = 3'd0;
    hi = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (phase_en[i]) begin
        lo = 3'(i);
        found_lo = 1'b1;
        if (3'(i) > phase) begin
          hi = 3'(i);
          found_hi = 1'b1;
        end
      end
    phase_nxt = phase;
    k_nxt = k;
    wrap = 1'b0;
    if (adv) begin
      if (phase > 3'd5) begin
        phase_nxt = found_lo ? lo : 3'd7;
        k_nxt = 5'd0;
      end else if (k != len - 5'd1)
        k_nxt = k + 5'd1;
      else begin
        k_nxt = 5'd0;
        phase_nxt = found_hi ? hi : found_lo ? lo : 3'd7;
        wrap = ~found_hi;
      end
    end
  end
  // pattern is computed from the next state so led changes on the same edge as phase/k
  always_comb begin
    lot = k_nxt[3:1] == 3'd0 ? 3'd2 : k_nxt[3:1] == 3'd1 ? 3'd6 : k_nxt[3:1] == 3'd2 ? 3'd0 :
          k_nxt[3:1] == 3'd3 ? 3'd3 : 3'd5;
    led_nxt = phase_nxt == 3'd0 ? 8'hFF << (5'd7 - k_nxt) :
              phase_nxt == 3'd1 ? 8'hFF << (k_nxt + 5'd1) :
              phase_nxt == 3'd2 ? (k_nxt[3] ? 8'h01 << k_nxt[2:0] : 8'h80 >> k_nxt[2:0]) :
              phase_nxt == 3'd3 ? (k_nxt[0] ? 8'h00 : 8'hFF) :
              phase_nxt == 3'd4 ? (k_nxt[0] ? 8'hF0 : 8'h0F) :
              phase_nxt == 3'd5 ? (k_nxt[0] ? 8'h00 : 8'h80 >> lot) : 8'h00;
  end
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// tb_led_pattern_scheduler: vector table, corner sequences and randomized run against a show-level model
module tb_led_pattern_scheduler;
  logic clk25 = 1'b0, rst_n = 1'b0, hold = 1'b0, step = 1'b0;
  logic [3:0] speed_sel = 4'd0;
  logic [5:0] phase_en = 6'h3F;
  logic [7:0] led;
  logic [2:0] phase;
  logic frame_done;
  typedef struct {
    int run;
    int en;
    int led;
    int ph;
    int fd;
  } vec_t;
  vec_t tbl[$];
  int show[6][20];
  int lens[6] = '{8, 8, 16, 20, 16, 10};
  int lot[10] = '{32, 0, 2, 0, 128, 0, 16, 0, 4, 0};
  int checks = 0, errors = 0, fd_cnt = 0, ph_other = 0;
  int mph, mk, mcnt, mfd;
  bit mstep_q;
  led_pattern_scheduler dut (
    .clk25(clk25), .rst_n(rst_n), .speed_sel(speed_sel), .phase_en(phase_en),
    .hold(hold), .step(step), .led(led), .phase(phase), .frame_done(frame_done)
  );
  always #5 clk25 = ~clk25;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic void add(input int r, input int e, input int l, input int p, input int f);
    vec_t v;
    v = '{r, e, l, p, f};
    tbl.push_back(v);
  endfunction
  function automatic int lowest(input logic [5:0] en);
    for (int i = 0; i < 6; i++) if (en[i]) return i;
    return 7;
  endfunction
  function automatic void nextp(input int p, input logic [5:0] en, output int q, output int w);
    int c;
    q = 7;
    w = 1;
    for (int d = 1; d <= 6; d++) begin
      c = (p + d) % 6;
      if (en[c]) begin
        q = c;
        w = (c <= p) ? 1 : 0;
        break;
      end
    end
  endfunction
  function automatic int exp_led();
    return mph > 5 ? 0 : show[mph][mk];
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk25);
    #1;
    rst_n = 1'b1;
    mph = 7; mk = 0; mcnt = 0; mstep_q = 0; mfd = 0;
  endtask
  task automatic cyc();
    int per, w;
    bit adv;
    per = 1 << (3 + speed_sel);
    adv = hold ? (step && !mstep_q) : ((mcnt % per) == per - 1);
    mfd = 0;
    if (adv) begin
      if (mph > 5) begin
        if (phase_en != 0) begin
          mph = lowest(phase_en);
          mk = 0;
        end
      end else if (mk < lens[mph] - 1) mk++;
      else begin
        mk = 0;
        nextp(mph, phase_en, mph, w);
        mfd = w;
      end
    end
    mstep_q = step;
    mcnt++;
    @(posedge clk25);
    #1;
    if (frame_done) fd_cnt++;
    if (phase != 3 && phase != 7) ph_other++;
    chk("model_led", led, exp_led());
    chk("model_phase", phase, mph);
    chk("model_frame_done", frame_done, mfd);
  endtask
  initial begin
    for (int kk = 0; kk < 20; kk++) begin
      if (kk < 8) begin
        show[0][kk] = 255 - (255 >> (kk + 1));
        show[1][kk] = (256 - (1 << (kk + 1))) & 255;
      end
      if (kk < 16) begin
        show[2][kk] = kk < 8 ? 1 << (7 - kk) : 1 << (kk - 8);
        show[4][kk] = kk % 2 ? 240 : 15;
      end
      show[3][kk] = kk % 2 ? 0 : 255;
      if (kk < 10) show[5][kk] = lot[kk];
    end
    add(7, 'h3F, 'h00, 7, 0); add(1, 'h3F, 'h80, 0, 0); add(56, 'h3F, 'hFF, 0, 0);
    add(8, 'h3F, 'hFE, 1, 0); add(56, 'h3F, 'h00, 1, 0); add(8, 'h3F, 'h80, 2, 0);
    add(56, 'h3F, 'h01, 2, 0); add(8, 'h3F, 'h01, 2, 0); add(56, 'h3F, 'h80, 2, 0);
    add(8, 'h3F, 'hFF, 3, 0); add(8, 'h3F, 'h00, 3, 0); add(144, 'h3F, 'h00, 3, 0);
    add(8, 'h3F, 'h0F, 4, 0); add(120, 'h3F, 'hF0, 4, 0);
    for (int i = 0; i < 10; i++) add(8, 'h3F, lot[i], 5, 0);
    add(8, 'h3F, 'h80, 0, 1); add(1, 'h3F, 'h80, 0, 0);
    do_reset();
    chk("reset_led", led, 0);
    chk("reset_phase", phase, 7);
    chk("reset_frame_done", frame_done, 0);
    fd_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      phase_en = 6'(tbl[i].en);
      repeat (tbl[i].run) cyc();
      chk($sformatf("vec%0d_led", i), led, tbl[i].led);
      chk($sformatf("vec%0d_phase", i), phase, tbl[i].ph);
      chk($sformatf("vec%0d_frame_done", i), frame_done, tbl[i].fd);
    end
    chk("frame_pulse_count", fd_cnt, 1);
    repeat (560) cyc();
    chk("pre_async_phase", phase, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_phase", phase, 7);
    chk("async_frame_done", frame_done, 0);
    @(posedge clk25);
    #1;
    rst_n = 1'b1;
    mph = 7; mk = 0; mcnt = 0; mstep_q = 0; mfd = 0;
    phase_en = 6'h08;
    do_reset();
    fd_cnt = 0;
    ph_other = 0;
    repeat (489) cyc();
    chk("blink_only_frames", fd_cnt, 3);
    chk("blink_only_other_phase", ph_other, 0);
    chk("blink_only_phase", phase, 3);
    phase_en = 6'h3F;
    hold = 1'b1;
    do_reset();
    repeat (1000) cyc();
    chk("hold_idle_phase", phase, 7);
    chk("hold_idle_led", led, 0);
    step = 1'b1; cyc(); step = 1'b0; repeat (5) cyc();
    chk("step1_led", led, 'h80);
    step = 1'b1; repeat (50) cyc(); step = 1'b0; repeat (3) cyc();
    chk("step2_led", led, 'hC0);
    step = 1'b1; cyc(); step = 1'b0; cyc();
    chk("step3_led", led, 'hE0);
    chk("step3_phase", phase, 0);
    hold = 1'b0;
    do_reset();
    repeat (168) cyc();
    chk("bounce_k4_led", led, 'h08);
    chk("bounce_k4_phase", phase, 2);
    phase_en = 6'h00;
    repeat (88) cyc();
    chk("bounce_end_led", led, 'h80);
    chk("bounce_end_phase", phase, 2);
    repeat (8) cyc();
    chk("to_idle_phase", phase, 7);
    chk("to_idle_led", led, 0);
    chk("to_idle_frame_done", frame_done, 1);
    phase_en = 6'h3F;
    repeat (8) cyc();
    chk("reenter_phase", phase, 0);
    chk("reenter_led", led, 'h80);
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(199) == 0) phase_en = 6'($urandom);
      if ($urandom_range(499) == 0) speed_sel = 4'($urandom_range(3));
      if ($urandom_range(299) == 0) hold = ~hold;
      if ($urandom_range(3) == 0) step = ~step;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_scheduler.md
# led_pattern_scheduler

Sequencer for the 8-LED output of the blinky tile. It divides the tile clock into a programmable step tick and walks a fixed six-phase light show: fill, drain, bounce, blink, halves, lottery. A per-phase enable mask selects which phases run, and hold/step inputs support single-stepping. It drives the `io_out` LED byte directly; the tile top maps `io_in` bits onto its inputs.

## Interface
- `PRESCALE_W`, default 19: prescaler counter width; must be ≥ 18 so that `speed_sel` = 15 is reachable.
- `clk25`, input, 1: tile clock (`io_in[0]`); all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `speed_sel`, input, 4: step period is 2^(3+speed_sel) clocks.
- `phase_en`, input, 6: bit p enables phase p.
- `hold`, input, 1: 1 = ignore ticks; advance only on `step` rising edges.
- `step`, input, 1: single-step request, synchronous to `clk25`, level input.
- `led`, output, 8: registered LED pattern.
- `phase`, output, 3: current phase code.
- `frame_done`, output, 1: one-cycle pulse at end of frame.

## Operation
- Prescaler: free-running `PRESCALE_W`-bit up-counter `cnt`, wraps at all-ones.
  - `tick` = 1 when `cnt[2+speed_sel:0]` is all ones, using the live `speed_sel`.
  - `speed_sel` changes take effect immediately; no glitch filtering is required.
- Step edge detect: `step_q` register holds the previous `step`.
  - `step_rise` = `step & ~step_q`.
- Advance event: `adv` = `hold ? step_rise : tick`.
- State: `phase` (3 b) and step index `k` (5 b).
- Phase codes, lengths and patterns, where k runs from 0 to len-1:
  - FILL=0, len 8: `led = 8'hFF << (7-k)`, giving 80, C0 … FF.
  - DRAIN=1, len 8: `led = 8'hFF << (k+1)`, giving FE, FC … 00 (8-bit truncation).
  - BOUNCE=2, len 16: k<8: `8'h80 >> k`; k≥8: `8'h01 << (k-8)`.
  - BLINK=3, len 20: k even FF, odd 00.
  - HALVES=4, len 16: k even 0F, odd F0.
  - LOTTERY=5, len 10: k odd 00; k even `8'h80 >> pos[k/2]`, with pos = {2,6,0,3,5}.
  - IDLE=7: `led` = 00.
- On `adv` in an active phase with k < len-1: k ← k+1.
- On `adv` in an active phase with k = len-1: k ← 0, then search for the next phase.
  - Search for the lowest enabled phase with code > current.
  - If none, wrap and search for the lowest enabled phase with code ≥ 0; this wrap asserts `frame_done`.
  - If `phase_en` = 0, go to IDLE and assert `frame_done`.
- On `adv` in IDLE: if `phase_en` ≠ 0, enter the lowest enabled phase with k=0; otherwise stay in IDLE. No `frame_done` either way.
- `phase_en` is sampled only at phase transitions. Disabling the running phase lets it finish.
- With a single enabled phase, wrap goes back to the same phase and `frame_done` pulses once per pass.
- Phase codes 6 and 7 are both treated as IDLE.

## Timing
- Reset state, entered asynchronously: `cnt`=0, `step_q`=0, `phase`=7, k=0, `led`=00, `frame_done`=0.
- `led`, `phase` and k all update on the same edge that consumes `adv`. `led` is registered and reflects the new (phase, k) with no extra latency.
- `frame_done` is high for exactly the one cycle following the wrap edge. It is never high twice in a row, even when `speed_sel`=0.
- Full frame with all phases enabled: 78 advances from FILL k=0 back to FILL k=0.
- First tick after reset with `speed_sel`=0: `cnt` reaches 7 at cycle 7, so the first advance is consumed at edge 8 and the next at edge 16.
- `hold` does not stop `cnt`.
- Releasing `hold` resumes on the next natural tick. No catch-up for missed ticks.
- Simultaneous `tick` and `step_rise` while `hold`=1: one advance only.
- Simultaneous `tick` and `step_rise` while `hold`=0: one advance only.

## Test plan
- Reset, `phase_en`=3F, `speed_sel`=0, `hold`=0:
  - `led`=00 and `phase`=7 until edge 8.
  - Edge 8: `led`=80, `phase`=0.
  - Edge 64: `led`=FF.
  - Edge 72: `phase`=1, `led`=FE.
- Full frame, `speed_sel`=0:
  - LOTTERY `led` sequence is 20,00,02,00,80,00,10,00,04,00.
  - `frame_done` pulses exactly once, one cycle after the LOTTERY→FILL edge, 78 advances after FILL entry; `led` becomes 80 on that edge.
- `phase_en`=08 from reset:
  - `phase` stays 3; `led` alternates FF/00.
  - `frame_done` pulses every 20 advances.
  - No other phase code ever appears.
- `hold`=1, `speed_sel`=0, 1000 clocks, no step: no state change.
- `hold`=1, `step` pulsed 3 times, including one held high 50 cycles: exactly 3 advances, `led` 80→C0→E0 from IDLE.
- Mid-frame control:
  - Clear `phase_en` to 00 at BOUNCE k=4: BOUNCE completes to k=15 (`led`=80); the next advance gives IDLE, `led`=00 and a `frame_done` pulse.
  - Then set `phase_en`=3F: the next advance enters FILL with `led`=80.
- Assert `rst_n`=0 mid-LOTTERY between clock edges: `led`=00, `phase`=7 and `frame_done`=0 immediately, without a clock edge.
